word_or_distributor: RTL and testbench

// Fans one input word out to WORD_COUNT lanes, under a per-word destination

---
 rtl/word_or_distributor.sv | 61 ++++++
 tb/tb_word_or_distributor.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/word_or_distributor.sv
// Fans one held word out to WORD_COUNT valid/ready lanes under a per-word mask.
// Idle lanes drive zero data so any lane set can be OR-combined downstream.
module word_or_distributor #(
    parameter int unsigned WORD_WIDTH  = 32,
    parameter int unsigned WORD_COUNT  = 4,
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [WORD_WIDTH-1:0]            in_data,
    input  logic [WORD_COUNT-1:0]            in_mask,
    output logic [WORD_COUNT-1:0]            out_valid,
    input  logic [WORD_COUNT-1:0]            out_ready,
    output logic [WORD_WIDTH*WORD_COUNT-1:0] out_data,
    output logic [COUNT_WIDTH-1:0]           drop_count
);

    logic [WORD_WIDTH-1:0]  held;
    logic [WORD_COUNT-1:0]  pending;
    logic [WORD_COUNT-1:0]  remaining;
    logic                   accept;
    logic                   drop;

    // Lanes still owed the held word after this cycle's handshakes.
    assign remaining = pending & ~(pending & out_ready);
    assign in_ready  = (remaining == '0);
    assign accept    = in_valid & in_ready;
    assign drop      = accept & (in_mask == '0);
    assign out_valid = pending;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            held    <= '0;
            pending <= '0;
        end else begin
            pending <= accept ? in_mask : remaining;
            if (accept && !drop) begin
                held <= in_data;
            end
        end
    end

    // Zero-mask words are counted, saturating at all-ones.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + COUNT_WIDTH'(1);
        end
    end

    always_comb begin
        out_data = '0;
        for (int unsigned i = 0; i < WORD_COUNT; i++) begin
            out_data[WORD_WIDTH*i +: WORD_WIDTH] = pending[i] ? held : '0;
        end
    end

endmodule

// File: tb/tb_word_or_distributor.sv
// Directed and random checks of word_or_distributor against per-lane word queues.
module tb_word_or_distributor;

    localparam int unsigned WW = 32;
    localparam int unsigned WC = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic           in_valid;
    logic [WW-1:0]  in_data;
    logic [WC-1:0]  in_mask;
    logic [WC-1:0]  out_ready;

    logic           in_ready,   in_ready_b;
    logic [WC-1:0]  out_valid,  out_valid_b;
    logic [WW*WC-1:0] out_data, out_data_b;
    logic [15:0]    drop_count;
    logic [1:0]     drop_count_b;

    int n_tests = 0;
    int n_fail  = 0;
    int drops   = 0;
    logic [WW-1:0] lq [WC][$];

    always #5 clock = ~clock;

    word_or_distributor #(.WORD_WIDTH(WW), .WORD_COUNT(WC), .COUNT_WIDTH(16)) dut (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .drop_count(drop_count));

    word_or_distributor #(.WORD_WIDTH(WW), .WORD_COUNT(WC), .COUNT_WIDTH(2)) dut_b (
        .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_mask(in_mask), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .drop_count(drop_count_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WW-1:0] lane(input logic [WW*WC-1:0] bus, input int i);
        return bus[WW*i +: WW];
    endfunction

    function automatic logic [WW-1:0] or_reduce(input logic [WW*WC-1:0] bus);
        logic [WW-1:0] r = '0;
        for (int i = 0; i < WC; i++) r |= bus[WW*i +: WW];
        return r;
    endfunction

    // Checks every output against the lane queues, then advances one clock.
    task automatic step(input logic v, input logic [WC-1:0] m, input logic [WW-1:0] d,
                        input logic [WC-1:0] r, output bit acc);
        logic [WC-1:0] ev;
        logic [WW*WC-1:0] ed;
        bit all_done;
        in_valid = v; in_mask = m; in_data = d; out_ready = r;
        #1;
        ev = '0; ed = '0; all_done = 1'b1;
        for (int i = 0; i < WC; i++) begin
            if (lq[i].size() != 0) begin
                ev[i] = 1'b1;
                ed[WW*i +: WW] = lq[i][0];
                if (!r[i]) all_done = 1'b0;
            end
        end
        acc = v && all_done;
        chk("out_valid", 64'(out_valid), 64'(ev));
        for (int i = 0; i < WC; i++) chk($sformatf("lane%0d_data", i), 64'(lane(out_data, i)), 64'(lane(ed, i)));
        chk("in_ready", 64'(in_ready), 64'(all_done));
        chk("drop_count", 64'(drop_count), 64'((drops > 65535) ? 65535 : drops));
        chk("drop_count_sat2", 64'(drop_count_b), 64'((drops > 3) ? 3 : drops));
        chk("b_out_valid", 64'(out_valid_b), 64'(ev));
        chk("b_out_data", 64'(out_data_b), 64'(ed));
        @(posedge clock);
        for (int i = 0; i < WC; i++) if (ev[i] && r[i]) void'(lq[i].pop_front());
        if (acc) begin
            if (m == '0) drops++;
            else for (int i = 0; i < WC; i++) if (m[i]) lq[i].push_back(d);
        end
        @(negedge clock);
    endtask

    initial begin
        bit acc;
        int ok;
        logic v; logic [WC-1:0] m; logic [WW-1:0] d;

        // Reset with a word offered
        reset_n = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF; in_mask = 4'hF; out_ready = '0;
        repeat (2) @(negedge clock);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(or_reduce(out_data)), 64'd0);
        chk("rst_drop_count", 64'(drop_count), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        reset_n = 1'b1;

        // Unicast to lane 2
        step(1'b1, 4'b0100, 32'hDEADBEEF, 4'hF, acc);
        chk("uni_accept", 64'(acc), 64'd1);
        chk("uni_or", 64'(or_reduce(out_data)), 64'hDEADBEEF);
        step(1'b0, 4'b0000, 32'h0, 4'hF, acc);
        step(1'b0, 4'b0000, 32'h0, 4'hF, acc);

        // Multicast 1011 with lanes 1,3 stalled, then released with next word offered
        step(1'b1, 4'b1011, 32'hA5A5_0001, 4'hF, acc);
        step(1'b1, 4'b0110, 32'h0000_0BB0, 4'b0001, acc);
        chk("mc_stall_ready", 64'(in_ready), 64'd0);
        step(1'b1, 4'b0110, 32'h0000_0BB0, 4'b0000, acc);
        chk("mc_stall_acc", 64'(acc), 64'd0);
        step(1'b1, 4'b0110, 32'h0000_0BB0, 4'b1010, acc);
        chk("mc_release_acc", 64'(acc), 64'd1);
        step(1'b0, 4'b0000, 32'h0, 4'hF, acc);

        // Streaming 8 words to every lane
        for (int k = 1; k <= 8; k++) begin
            step(1'b1, 4'hF, 32'(k), 4'hF, acc);
            chk($sformatf("stream_acc%0d", k), 64'(acc), 64'd1);
        end
        step(1'b0, 4'b0000, 32'h0, 4'hF, acc);

        // Reset mid-operation: lane0 done, lane1 stalled
        step(1'b1, 4'b0011, 32'h1234_5678, 4'hF, acc);
        step(1'b0, 4'b0000, 32'h0, 4'b0001, acc);
        in_valid = 1'b0; out_ready = '0;
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_out_data", 64'(or_reduce(out_data)), 64'd0);
        chk("midrst_drop_count", 64'(drop_count), 64'd0);
        for (int i = 0; i < WC; i++) lq[i].delete();
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 4'b0010, 32'hCAFE_F00D, 4'hF, acc);
        chk("postrst_accept", 64'(acc), 64'd1);
        step(1'b0, 4'b0000, 32'h0, 4'hF, acc);

        // Zero-mask words: 3 then 2 more, 2-bit counter saturates
        for (int k = 0; k < 3; k++) step(1'b1, 4'b0000, 32'hBAD0_0000 + 32'(k), 4'hF, acc);
        step(1'b0, 4'b0000, 32'h0, 4'hF, acc);
        chk("drop3", 64'(drop_count), 64'd3);
        for (int k = 0; k < 2; k++) step(1'b1, 4'b0000, 32'h0, 4'h0, acc);
        step(1'b0, 4'b0000, 32'h0, 4'hF, acc);
        chk("drop5", 64'(drop_count), 64'd5);
        chk("drop5_sat2", 64'(drop_count_b), 64'd3);

        // Random traffic; producer holds its word stable until accepted
        ok = 1; v = 1'b0; m = '0; d = '0;
        for (int k = 0; k < 400; k++) begin
            if (ok != 0) begin
                v = ($urandom_range(0, 3) != 0);
                m = WC'($urandom_range(0, 15));
                d = $urandom;
            end
            step(v, m, d, WC'($urandom_range(0, 15)), acc);
            ok = (acc || !v) ? 1 : 0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
